vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised VGA timing generator and pixel output stage; next-generation replacement for the fixed-mode vga block.
// - Runs on the pixel clock, asks an external pixel source for colour via (pix_x, pix_y) and aligns syncs to that source's latency.
// - Drives hsync/vsync/r/g/b to the board pins, so any mode and colour depth comes from parameters alone.
// PARAMETERS
// - H_ACTIVE 1024 visible pixels per line; H_FP 24; H_SYNC 136; H_BP 160 (H_TOTAL=sum=1344)
// - V_ACTIVE 768 visible lines; V_FP 3; V_SYNC 6; V_BP 29 (V_TOTAL=sum=806)
// - HS_POL 0, VS_POL 0: sync active level (0 = active-low)
// - COLOR_W 3: bits per colour channel
// - PIX_LAT 1: pixel-source latency in clocks, 0..4
// PORTS
// - clk          in   1        pixel clock (65 MHz for default mode)
// - rst_n        in   1        asynchronous reset, active low
// - en           in   1        1 = run; 0 = freeze every register (counters, delay line, outputs)
// - pix_x        out  11       current column counter h_cnt, 0..H_TOTAL-1
// - pix_y        out  10       current line counter v_cnt, 0..V_TOTAL-1
// - pix_req      out  1        h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
// - r_in,g_in,b_in in COLOR_W  colour from source, valid PIX_LAT clocks after its (pix_x,pix_y)
// - hsync        out  1        horizontal sync, polarity HS_POL
// - vsync        out  1        vertical sync, polarity VS_POL
// - r,g,b        out  COLOR_W  pixel colour; forced 0 outside active area
// - de           out  1        data enable aligned with r/g/b
// - frame_start  out  1        one-clock pulse when pixel (0,0) is on r/g/b
// BEHAVIOUR
// - Reset values: h_cnt=v_cnt=0; hsync=~HS_POL, vsync=~VS_POL; r=g=b=0; de=0; frame_start=0; delay line holds these inactive values.
// - Reset asserts asynchronously mid-frame; outputs go to reset values at once; after rst_n release counting restarts at (0,0).
// - Counters: h_cnt increments each enabled clock, wraps H_TOTAL-1 -> 0; v_cnt increments only on h wrap, wraps V_TOTAL-1 -> 0 (both wrap same clock at (H_TOTAL-1,V_TOTAL-1)).
// - Stage-0 timing from counters: act=pix_req; hs_a = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs_a = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; fs = (h_cnt==0 && v_cnt==0).
// - pix_x/pix_y/pix_req are the counters themselves (no extra register); source samples them at clock t.
// - Stage-0 {act,hs_a,vs_a,fs} delayed PIX_LAT clocks (PIX_LAT=0: no delay).
// - Output register: at clock t+PIX_LAT+1 de=act_d, hsync=hs_a_d^~HS_POL, vsync=vs_a_d^~VS_POL, frame_start=fs_d, {r,g,b} = act_d ? {r_in,g_in,b_in} : 0.
// - Total latency counter->pins = PIX_LAT+1 clocks, identical for syncs, de and colour; vsync edges coincide with an hsync-period boundary.
// - en=0: no state changes anywhere; outputs hold last value; resuming continues the exact sequence (no skipped/duplicated pixel).
// - Colour inputs ignored (output 0) whenever act_d=0, regardless of source value.
// - Counter widths fixed at 11/10 bits; parameters must satisfy H_TOTAL<=2048, V_TOTAL<=1024 (elaboration-time check, $error otherwise).
// STRUCTURE
// - Package vga_pkg: mode constant sets (640x480@60, 800x600@60, 1024x768@60) as localparams, counter-width constants, the delay-line payload field order.
// - One sub-module: vga_delay_line #(W, DEPTH) -- enable-gated shift register with per-bit async reset value; DEPTH=0 is a wire.
// - Top holds counters, stage-0 decode, output register.
// TESTING (small mode: H 8/2/3/3 -> H_TOTAL 16; V 4/1/2/1 -> V_TOTAL 8; COLOR_W 3)
// - Reset then run, PIX_LAT=1 -> hsync low exactly for cycles where delayed h_cnt in 10..12, period 16 clocks; vsync low for lines 5..6, period 128 clocks.
// - Source returns r_in=pix_x[2:0] registered once (PIX_LAT=1) -> r on pins reads 0..7 on the 8 de-high clocks of each line, 0 on the other 8.
// - Drive r_in=g_in=b_in=3'b111 constantly -> r/g/b=7 only when de=1; 0 in blanking and vertical blanking lines 4..7.
// - frame_start -> one pulse every 128 clocks, coincident with first de=1 of line 0, PIX_LAT+1 clocks after h_cnt=v_cnt=0.
// - Deassert en for 5 clocks mid-line at h_cnt=6 -> all outputs frozen; after resume next pixel is h_cnt=7, frame period becomes 133 clocks once.
// - Assert rst_n=0 asynchronously mid-sync pulse -> hsync/vsync return inactive within same clock, de=0, rgb=0; after release pix_x=0,pix_y=0; repeat with HS_POL=1 and PIX_LAT=0,4.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator family: standard mode
// timings, counter widths and the layout of the delayed timing payload.
package vga_pkg;

    localparam int H_CNT_W     = 11;
    localparam int V_CNT_W     = 10;
    localparam int H_TOTAL_MAX = 2048;
    localparam int V_TOTAL_MAX = 1024;
    localparam int PIX_LAT_MAX = 4;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam vga_mode_t MODE_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
    localparam vga_mode_t MODE_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};

    // Stage-0 timing payload carried through the pixel-latency delay line.
    // Field order from MSB: act, hs, vs, fs. All-zero is the idle value.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
    } timing_t;

    localparam int      TIMING_W    = $bits(timing_t);
    localparam timing_t TIMING_IDLE = '0;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align timing flags with the pixel
// source latency. DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int             W       = 4,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, en};
            assign dout = din;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            // Shift one slot per enabled clock; reset loads the idle payload everywhere
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and pixel output stage. Counters address
// an external pixel source; sync/de/frame flags are delayed by the source
// latency so everything reaches the pins on the same clock.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = MODE_1024X768_60.h_active,
    parameter int H_FP     = MODE_1024X768_60.h_fp,
    parameter int H_SYNC   = MODE_1024X768_60.h_sync,
    parameter int H_BP     = MODE_1024X768_60.h_bp,
    parameter int V_ACTIVE = MODE_1024X768_60.v_active,
    parameter int V_FP     = MODE_1024X768_60.v_fp,
    parameter int V_SYNC   = MODE_1024X768_60.v_sync,
    parameter int V_BP     = MODE_1024X768_60.v_bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 3,
    parameter int PIX_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [H_CNT_W-1:0] pix_x,
    output logic [V_CNT_W-1:0] pix_y,
    output logic               pix_req,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               de,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > H_TOTAL_MAX) begin : g_h_check
            $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, H_TOTAL_MAX);
        end
        if (V_TOTAL > V_TOTAL_MAX) begin : g_v_check
            $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, V_TOTAL_MAX);
        end
        if (PIX_LAT < 0 || PIX_LAT > PIX_LAT_MAX) begin : g_lat_check
            $error("vga_timing_gen: PIX_LAT %0d outside 0..%0d", PIX_LAT, PIX_LAT_MAX);
        end
    endgenerate

    // Decode bounds carry one spare bit so a full 2048/1024 total cannot alias to 0.
    localparam logic [H_CNT_W-1:0] H_LAST    = H_CNT_W'(H_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_LAST    = V_CNT_W'(V_TOTAL - 1);
    localparam logic [H_CNT_W:0]   H_ACT_END = (H_CNT_W+1)'(H_ACTIVE);
    localparam logic [H_CNT_W:0]   HS_START  = (H_CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W:0]   HS_END    = (H_CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_CNT_W:0]   V_ACT_END = (V_CNT_W+1)'(V_ACTIVE);
    localparam logic [V_CNT_W:0]   VS_START  = (V_CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W:0]   VS_END    = (V_CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic [H_CNT_W:0]   h_ext;
    logic [V_CNT_W:0]   v_ext;
    timing_t            t0;
    timing_t            t_d;

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    // Raster counters: column every enabled clock, line on column wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign pix_x   = h_cnt;
    assign pix_y   = v_cnt;
    assign pix_req = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);

    // Stage-0 timing flags decoded straight from the counters
    always_comb begin
        t0     = TIMING_IDLE;
        t0.act = pix_req;
        t0.hs  = (h_ext >= HS_START) && (h_ext < HS_END);
        t0.vs  = (v_ext >= VS_START) && (v_ext < VS_END);
        t0.fs  = (h_cnt == '0) && (v_cnt == '0);
    end

    vga_delay_line #(
        .W       (TIMING_W),
        .DEPTH   (PIX_LAT),
        .RST_VAL (TIMING_IDLE)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (t0),
        .dout  (t_d)
    );

    // Pin register: apply sync polarity and blank colour outside the active area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else if (en) begin
            hsync       <= t_d.hs ^ ~HS_POL;
            vsync       <= t_d.vs ^ ~VS_POL;
            de          <= t_d.act;
            frame_start <= t_d.fs;
            r           <= t_d.act ? r_in : '0;
            g           <= t_d.act ? g_in : '0;
            b           <= t_d.act ? b_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen in a tiny 16x8 raster. Three instances run side
// by side (PIX_LAT 1/0/4, mixed sync polarities), each fed by a pipelined
// pixel source and checked against a scoreboard of expected pin values.
module tb_vga_timing_gen;

    localparam int H_TOTAL = 16;
    localparam int V_TOTAL = 8;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        logic       fs;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b1;
    int   num_checks = 0;
    int   num_errors = 0;

    // Free-running pixel clock, 10 time units per period
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any difference
    task automatic checkOutput(input string tag, input int actual, input int expected);
        num_checks++;
        if (actual != expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive enable at a falling edge, then let the given number of rising edges pass
    task automatic applyStimulus(input logic en_val, input int cycles);
        @(negedge clk);
        en = en_val;
        repeat (cycles) @(posedge clk);
    endtask

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int   LAT = (gi == 0) ? 1 : (gi == 1) ? 0 : 4;
            localparam logic HSP = (gi == 0) ? 1'b0 : 1'b1;
            localparam logic VSP = (gi == 2) ? 1'b1 : 1'b0;
            localparam exp_t IDLE = {~HSP, ~VSP, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0};

            logic [10:0] pix_x;
            logic [9:0]  pix_y;
            logic        pix_req;
            logic [2:0]  r_in, g_in, b_in, r, g, b;
            logic        hsync, vsync, de, frame_start;
            logic [2:0]  rpipe [5];
            logic [2:0]  gpipe [5];
            exp_t        sb_q [$];
            exp_t        last_exp = IDLE;
            int          mh = 0;
            int          mv = 0;
            int          since_fs = 0;
            int          paused = 0;
            logic        seen_fs = 1'b0;

            vga_timing_gen #(
                .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
                .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
                .HS_POL   (HSP), .VS_POL (VSP),
                .COLOR_W  (3), .PIX_LAT (LAT)
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .en          (en),
                .pix_x       (pix_x),
                .pix_y       (pix_y),
                .pix_req     (pix_req),
                .r_in        (r_in),
                .g_in        (g_in),
                .b_in        (b_in),
                .hsync       (hsync),
                .vsync       (vsync),
                .r           (r),
                .g           (g),
                .b           (b),
                .de          (de),
                .frame_start (frame_start)
            );

            // Pixel source: red = column, green = line, delayed LAT enabled clocks
            always @(posedge clk) begin
                if (en) begin
                    rpipe[0] <= pix_x[2:0];
                    gpipe[0] <= pix_y[2:0];
                    for (int k = 1; k < 5; k++) begin
                        rpipe[k] <= rpipe[k-1];
                        gpipe[k] <= gpipe[k-1];
                    end
                end
            end

            assign r_in = (LAT == 0) ? pix_x[2:0] : rpipe[(LAT == 0) ? 0 : LAT - 1];
            assign g_in = (LAT == 0) ? pix_y[2:0] : gpipe[(LAT == 0) ? 0 : LAT - 1];
            assign b_in = 3'b111;

            // On reset: restart the model and confirm pins drop to idle immediately
            always @(negedge rst_n) begin
                sb_q.delete();
                for (int k = 0; k < LAT; k++) sb_q.push_back(IDLE);
                mh = 0;
                mv = 0;
                last_exp = IDLE;
                since_fs = 0;
                paused = 0;
                seen_fs = 1'b0;
                #1;
                checkOutput($sformatf("L%0d_rst_hsync", LAT), hsync, IDLE.hsync);
                checkOutput($sformatf("L%0d_rst_vsync", LAT), vsync, IDLE.vsync);
                checkOutput($sformatf("L%0d_rst_de", LAT), de, 0);
                checkOutput($sformatf("L%0d_rst_fs", LAT), frame_start, 0);
                checkOutput($sformatf("L%0d_rst_rgb", LAT), {r, g, b}, 0);
                checkOutput($sformatf("L%0d_rst_req", LAT), pix_req, 1);
            end

            // After release the raster must start from the origin
            always @(posedge rst_n) begin
                #1;
                checkOutput($sformatf("L%0d_rel_x", LAT), pix_x, 0);
                checkOutput($sformatf("L%0d_rel_y", LAT), pix_y, 0);
            end

            // Scoreboard: push expected pins for the current raster position on each
            // enabled edge, pop the one due now, and compare shortly after the edge
            always @(posedge clk) begin
                exp_t e;
                logic act;
                logic en_s;
                if (rst_n) begin
                    en_s = en;
                    if (en_s) begin
                        act     = (mh < 8) && (mv < 4);
                        e.hsync = (mh >= 10 && mh < 13) ? HSP : ~HSP;
                        e.vsync = (mv >= 5 && mv < 7) ? VSP : ~VSP;
                        e.de    = act;
                        e.fs    = (mh == 0) && (mv == 0);
                        e.r     = act ? 3'(mh) : 3'd0;
                        e.g     = act ? 3'(mv) : 3'd0;
                        e.b     = act ? 3'd7 : 3'd0;
                        sb_q.push_back(e);
                        mh = (mh == H_TOTAL - 1) ? 0 : mh + 1;
                        if (mh == 0) mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
                    end
                    #1;
                    if (en_s) begin
                        if (sb_q.size() == 0) checkOutput($sformatf("L%0d_sb_empty", LAT), 0, 1);
                        else last_exp = sb_q.pop_front();
                    end
                    checkOutput($sformatf("L%0d_pix_x", LAT), pix_x, mh);
                    checkOutput($sformatf("L%0d_pix_y", LAT), pix_y, mv);
                    checkOutput($sformatf("L%0d_hsync", LAT), hsync, last_exp.hsync);
                    checkOutput($sformatf("L%0d_vsync", LAT), vsync, last_exp.vsync);
                    checkOutput($sformatf("L%0d_de", LAT), de, last_exp.de);
                    checkOutput($sformatf("L%0d_fs", LAT), frame_start, last_exp.fs);
                    checkOutput($sformatf("L%0d_r", LAT), r, last_exp.r);
                    checkOutput($sformatf("L%0d_g", LAT), g, last_exp.g);
                    checkOutput($sformatf("L%0d_b", LAT), b, last_exp.b);
                    since_fs++;
                    if (!en_s) paused++;
                    if (en_s && frame_start) begin
                        if (seen_fs) checkOutput($sformatf("L%0d_fs_period", LAT), since_fs, 128 + paused);
                        seen_fs = 1'b1;
                        since_fs = 0;
                        paused = 0;
                    end
                end
            end
        end
    endgenerate

    // Main sequence: reset, free run, mid-line pause, mid-sync reset, free run
    initial begin
        int guard;
        $display("[TB] starting vga_timing_gen bench");
        #2 rst_n = 1'b0;
        #21 rst_n = 1'b1;
        applyStimulus(1'b1, 300);

        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (g_dut[0].pix_x != 11'd6 && guard < 100);
        checkOutput("wait_x6", int'(guard < 100), 1);
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("frozen_x", g_dut[0].pix_x, 6);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resume_x", g_dut[0].pix_x, 7);
        applyStimulus(1'b1, 300);

        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(g_dut[0].hsync == 1'b0 && g_dut[0].vsync == 1'b0) && guard < 300);
        checkOutput("wait_sync", int'(guard < 300), 1);
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        applyStimulus(1'b1, 300);

        #20;
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
